// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_pkg
// Description : Shared constants, types and helpers for the four-master
//               round-robin bus arbiter (bus_arbiter, bus_arb_next_sel).
//               Request and grant lines are active-low throughout.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

    // Number of bus masters and width of the owner index
    localparam int c_NUM_MASTERS = 4;
    localparam int c_OWNER_W     = 2;

    // Width of the optional hold counter
    localparam int c_HOLD_CNT_W  = 16;

    // Active-low request/grant polarity
    localparam logic c_ENABLE  = 1'b0;
    localparam logic c_DISABLE = 1'b1;

    // Owner index type
    typedef logic [c_OWNER_W-1:0] owner_t;

    // Owner register encodings (one state per master)
    localparam logic [1:0] OWN0 = 2'd0;
    localparam logic [1:0] OWN1 = 2'd1;
    localparam logic [1:0] OWN2 = 2'd2;
    localparam logic [1:0] OWN3 = 2'd3;

    // Decode an owner index into an active-low one-hot grant vector
    function automatic logic [c_NUM_MASTERS-1:0] grant_decode(input owner_t own);
        logic [c_NUM_MASTERS-1:0] g;
        g      = {c_NUM_MASTERS{c_DISABLE}};
        g[own] = c_ENABLE;
        return g;
    endfunction

endpackage : bus_arbiter_pkg
`default_nettype wire

// File: rtl/bus_arb_next_sel.sv
`default_nettype none
// ============================================================================
// Module      : bus_arb_next_sel
// Description : Combinational round-robin search. Starting after the current
//               owner, scans owner+1, owner+2, owner+3 (mod 4) and returns the
//               first master with an active (low) request. The current owner
//               is never a candidate; o_found is low when nobody else asks.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arb_next_sel
    import bus_arbiter_pkg::*;
(
    input  logic [1:0] i_owner,     // current owner index
    input  logic [3:0] i_req_n,     // active-low requests, bit k = master k
    output logic [1:0] o_next,      // selected next owner
    output logic       o_found      // a requester other than the owner exists
);

    logic [1:0] w_idx;

    // Priority scan in rotating order; first hit wins
    always_comb begin
        o_next  = i_owner;
        o_found = 1'b0;
        w_idx   = i_owner;
        for (int i = 1; i < c_NUM_MASTERS; i++) begin
            w_idx = i_owner + 2'(i);
            if (!o_found && (i_req_n[w_idx] == c_ENABLE)) begin
                o_next  = w_idx;
                o_found = 1'b1;
            end
        end
    end

endmodule : bus_arb_next_sel
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Four-master round-robin arbiter for the shared system bus.
//               Samples active-low requests and drives exactly one active-low
//               registered grant at all times. Ownership passes only when the
//               owner releases its request (park on last owner otherwise).
//               Optional feature macro BUS_ARB_TIMEOUT_EN adds a 16-bit hold
//               counter that forces handover after TIMEOUT_CYCLES contested
//               cycles and pulses timeout_evt.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16   // legal range 2..65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    output logic [1:0] owner,
    output logic       timeout_evt
);

    // ------------------------------------------------------------------------
    // Request collection and next-owner search
    // ------------------------------------------------------------------------
    logic [3:0] w_req_n;
    logic [1:0] w_next;
    logic       w_found;
    logic       w_owner_req;
    logic       w_release;

    assign w_req_n = {m3_req_, m2_req_, m1_req_, m0_req_};

    // Owner state; grants are registered alongside so they always mirror it
    logic [1:0] r_owner;
    logic [3:0] r_grnt_n;
    logic [1:0] w_owner_nxt;

    bus_arb_next_sel u_next_sel (
        .i_owner (r_owner),
        .i_req_n (w_req_n),
        .o_next  (w_next),
        .o_found (w_found)
    );

    // Owner still asking for the bus
    assign w_owner_req = (w_req_n[r_owner] == c_ENABLE);

    // Owner let go and somebody else is waiting: hand over
    assign w_release   = !w_owner_req && w_found;

`ifdef BUS_ARB_TIMEOUT_EN
    // ------------------------------------------------------------------------
    // Hold-timeout path
    // ------------------------------------------------------------------------
    logic [c_HOLD_CNT_W-1:0] r_hold_cnt;
    logic [c_HOLD_CNT_W-1:0] w_cnt_nxt;
    logic                    r_timeout_evt;
    logic                    w_contested;
    logic                    w_expire;

    // Contested means the owner holds while another master is waiting; the
    // search only ever looks at the other three, so w_found says exactly that.
    assign w_contested = w_owner_req && w_found;
    assign w_expire    = w_contested &&
                         (r_hold_cnt == c_HOLD_CNT_W'(TIMEOUT_CYCLES - 1));

    // Next owner and counter: release or expiry both hand over and clear
    always_comb begin
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_hold_cnt;
        if (w_release || w_expire) begin
            w_owner_nxt = w_next;
            w_cnt_nxt   = '0;
        end else if (w_contested) begin
            w_cnt_nxt   = r_hold_cnt + 1'b1;
        end
    end

    // Owner, grant, counter and event registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner       <= OWN0;
            r_grnt_n      <= grant_decode(OWN0);
            r_hold_cnt    <= '0;
            r_timeout_evt <= 1'b0;
        end else begin
            r_owner       <= w_owner_nxt;
            r_grnt_n      <= grant_decode(w_owner_nxt);
            r_hold_cnt    <= w_cnt_nxt;
            r_timeout_evt <= w_expire;
        end
    end

    assign timeout_evt = r_timeout_evt;
`else
    // ------------------------------------------------------------------------
    // No timeout: owner holds indefinitely
    // ------------------------------------------------------------------------
    logic [c_HOLD_CNT_W-1:0] w_unused_timeout;
    assign w_unused_timeout = c_HOLD_CNT_W'(TIMEOUT_CYCLES);

    // Next owner changes only on a release with a waiting requester
    always_comb begin
        w_owner_nxt = r_owner;
        if (w_release) begin
            w_owner_nxt = w_next;
        end
    end

    // Owner and grant registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner  <= OWN0;
            r_grnt_n <= grant_decode(OWN0);
        end else begin
            r_owner  <= w_owner_nxt;
            r_grnt_n <= grant_decode(w_owner_nxt);
        end
    end

    assign timeout_evt = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs straight from flops
    // ------------------------------------------------------------------------
    assign owner    = r_owner;
    assign m0_grnt_ = r_grnt_n[0];
    assign m1_grnt_ = r_grnt_n[1];
    assign m2_grnt_ = r_grnt_n[2];
    assign m3_grnt_ = r_grnt_n[3];

endmodule : bus_arbiter
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Directed self-checking bench for bus_arbiter. Inputs change
//               on the falling edge, outputs are sampled on the falling edge
//               after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       m0_req_, m1_req_, m2_req_, m3_req_;
    logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
    logic [1:0] owner;
    logic       timeout_evt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m0_req_     (m0_req_),
        .m1_req_     (m1_req_),
        .m2_req_     (m2_req_),
        .m3_req_     (m3_req_),
        .m0_grnt_    (m0_grnt_),
        .m1_grnt_    (m1_grnt_),
        .m2_grnt_    (m2_grnt_),
        .m3_grnt_    (m3_grnt_),
        .owner       (owner),
        .timeout_evt (timeout_evt)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grant vector {m3,m2,m1,m0} for each owner, written out by hand
    function automatic logic [3:0] exp_grnt(input logic [1:0] o);
        case (o)
            2'd0:    return 4'b1110;
            2'd1:    return 4'b1101;
            2'd2:    return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic expect_own(input string tag, input logic [1:0] o, input logic evt);
        chk({tag, ".owner"}, 8'(owner), 8'(o));
        chk({tag, ".grnt"},  8'({m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_}), 8'(exp_grnt(o)));
        chk({tag, ".evt"},   8'(timeout_evt), 8'(evt));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // r = {m3,m2,m1,m0} active-low
    task automatic set_req(input logic [3:0] r);
        {m3_req_, m2_req_, m1_req_, m0_req_} = r;
    endtask

    initial begin
        reset = 1'b1;
        set_req(4'b1111);
        @(negedge clk);
        step(2);
        expect_own("rst", 2'd0, 1'b0);

        // Parked on master 0 with nobody requesting
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            expect_own("park0", 2'd0, 1'b0);
        end

        // Master 0 holds alone
        set_req(4'b1110);
        step(3);
        expect_own("hold0", 2'd0, 1'b0);

        // m0 releases while m2 requests on the same edge
        set_req(4'b1011);
        #1;
        chk("no_comb", 8'({m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_}), 8'(4'b1110));
        step(1);
        expect_own("rel2", 2'd2, 1'b0);

        // Everyone requests; owner 2 keeps the bus
        set_req(4'b0000);
        step(1);
        expect_own("hold2", 2'd2, 1'b0);

        // Reset mid-transfer
        reset = 1'b1;
        step(1);
        expect_own("midrst", 2'd0, 1'b0);
        reset = 1'b0;

        // Round robin: each owner releases for one cycle
        set_req(4'b0001);
        step(1);
        expect_own("rr1", 2'd1, 1'b0);
        set_req(4'b0010);
        step(1);
        expect_own("rr2", 2'd2, 1'b0);
        set_req(4'b0100);
        step(1);
        expect_own("rr3", 2'd3, 1'b0);
        set_req(4'b1000);
        step(1);
        expect_own("rr0_wrap", 2'd0, 1'b0);

        // Rotate back to owner 3
        set_req(4'b0001);
        step(1);
        set_req(4'b0010);
        step(1);
        set_req(4'b0100);
        step(1);
        expect_own("to3", 2'd3, 1'b0);

        // Owner 3 releases, only m1 and m0 request: search hits 0 first
        set_req(4'b1100);
        step(1);
        expect_own("srch0", 2'd0, 1'b0);

        // All release: park on 0; then owner re-requests and keeps it
        set_req(4'b1111);
        step(1);
        expect_own("park_rel", 2'd0, 1'b0);
        set_req(4'b1110);
        step(1);
        expect_own("rereq", 2'd0, 1'b0);

        // Hand to master 1, then m3 contests while m1 holds
        set_req(4'b1101);
        step(1);
        expect_own("to1", 2'd1, 1'b0);
        set_req(4'b0101);
`ifdef BUS_ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            step(1);
            expect_own("contest", 2'd1, 1'b0);
        end
        step(1);
        expect_own("tmo", 2'd3, 1'b1);
        step(1);
        expect_own("tmo_pulse", 2'd3, 1'b0);
`else
        for (int i = 0; i < 100; i++) begin
            step(1);
            expect_own("hold1", 2'd1, 1'b0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bus_arbiter
`default_nettype wire
